dmem_arbiter: RTL and testbench

- Shares the single-port data memory between two requesters:
  - the pipeline memory stage (port P);
  - a secondary requester (port X), e.g. program loader or debug/DMA agent.
- P has default priority.
- X is served in idle slots, by a starvation-forced slot, or by a bounded burst; P is stalled while X owns the memory.
- Sits between the memory stage and data_memory; p_stall feeds the hazard unit.

---
 rtl/dmem_arbiter.sv | 108 ++++++++++
 tb/tb_dmem_arbiter.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter.sv
// Shares single-port data memory between pipeline (P, default priority) and secondary requester X; grant is combinational, X read data 1 cycle later.
// Backpressure: P sees p_stall while X is served; X holds x_req stable until x_gnt, forced after MAX_WAIT denials, bursts capped at MAX_BURST.
module dmem_arbiter #(
    parameter int AW        = 32,
    parameter int DW        = 32,
    parameter int MAX_WAIT  = 4,
    parameter int MAX_BURST = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          p_req,
    input  logic          p_we,
    input  logic [AW-1:0] p_addr,
    input  logic [DW-1:0] p_wdata,
    output logic [DW-1:0] p_rdata,
    output logic          p_stall,
    input  logic          x_req,
    input  logic          x_we,
    input  logic          x_burst,
    input  logic [AW-1:0] x_addr,
    input  logic [DW-1:0] x_wdata,
    output logic          x_gnt,
    output logic          x_rvalid,
    output logic [DW-1:0] x_rdata,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rd
);

    localparam int WCW = $clog2(MAX_WAIT + 1);
    localparam int BCW = $clog2(MAX_BURST + 1);
    localparam logic [WCW-1:0] WAIT_MAX   = WCW'(MAX_WAIT);
    localparam logic [BCW-1:0] BURST_LAST = BCW'(MAX_BURST - 1);
    localparam bit BURST_EN = (MAX_BURST > 1);

    typedef enum logic {PIPE, XBURST} state_t;

    state_t         state, nextState;
    logic [WCW-1:0] waitCnt, nextWait;
    logic [BCW-1:0] burstCnt, nextBurst;
    logic           xGnt;

    always_comb begin
        nextState = state;
        nextWait  = waitCnt;
        nextBurst = burstCnt;
        xGnt      = 1'b0;

        if (state == XBURST) begin
            xGnt = rst & x_req;
        end else begin
            xGnt = rst & x_req & (~p_req | (waitCnt == WAIT_MAX));
        end

        if (xGnt || !x_req) begin
            nextWait = '0;
        end else if (waitCnt != WAIT_MAX) begin
            nextWait = waitCnt + WCW'(1);
        end

        case (state)
            PIPE: begin
                if (xGnt && x_burst && BURST_EN) begin
                    nextState = XBURST;
                    nextBurst = BCW'(1);
                end
            end
            XBURST: begin
                // Dropping x_burst still grants this cycle; ownership ends afterwards.
                if (!x_req || !x_burst || burstCnt == BURST_LAST) begin
                    nextState = PIPE;
                    nextBurst = '0;
                    nextWait  = '0;
                end else begin
                    nextBurst = burstCnt + BCW'(1);
                end
            end
            default: nextState = PIPE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= PIPE;
            waitCnt  <= '0;
            burstCnt <= '0;
            x_rvalid <= 1'b0;
            x_rdata  <= '0;
        end else begin
            state    <= nextState;
            waitCnt  <= nextWait;
            burstCnt <= nextBurst;
            x_rvalid <= xGnt & ~x_we;
            if (xGnt && !x_we) begin
                x_rdata <= mem_rd;
            end
        end
    end

    assign x_gnt     = xGnt;
    assign p_stall   = p_req & xGnt;
    assign mem_we    = xGnt ? x_we : (rst & p_req & p_we);
    assign mem_addr  = xGnt ? x_addr : p_addr;
    assign mem_wdata = xGnt ? x_wdata : p_wdata;
    assign p_rdata   = mem_rd;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: directed schedules with a read-data scoreboard and a simple synchronous-write memory.
module tb_dmem_arbiter;

    logic        clk;
    logic        rst;
    logic        p_req, p_we;
    logic [31:0] p_addr, p_wdata, p_rdata;
    logic        p_stall;
    logic        x_req, x_we, x_burst;
    logic [31:0] x_addr, x_wdata;
    logic        x_gnt, x_rvalid;
    logic [31:0] x_rdata;
    logic        mem_we;
    logic [31:0] mem_addr, mem_wdata, mem_rd;

    logic [31:0] mem [0:255];
    logic [31:0] expQ [$];
    int nCompared;
    int nMismatched;

    dmem_arbiter #(.AW(32), .DW(32), .MAX_WAIT(4), .MAX_BURST(8)) dut (
        .clk(clk), .rst(rst),
        .p_req(p_req), .p_we(p_we), .p_addr(p_addr), .p_wdata(p_wdata),
        .p_rdata(p_rdata), .p_stall(p_stall),
        .x_req(x_req), .x_we(x_we), .x_burst(x_burst), .x_addr(x_addr),
        .x_wdata(x_wdata), .x_gnt(x_gnt), .x_rvalid(x_rvalid), .x_rdata(x_rdata),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rd(mem_rd)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign mem_rd = mem[mem_addr[9:2]];
    always @(posedge clk) begin
        if (mem_we) mem[mem_addr[9:2]] <= mem_wdata;
    end

    task automatic checkEq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        nCompared++;
        if (act !== exp) begin
            nMismatched++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Sample point of every cycle; retires scoreboard entries when read data returns.
    task automatic atNeg();
        @(negedge clk);
        if (!rst) begin
            expQ.delete();
        end else if (x_rvalid) begin
            checkEq("sb_has_expectation", 32'(expQ.size() > 0), 32'd1);
            if (expQ.size() > 0) checkEq("sb_x_rdata", x_rdata, expQ.pop_front());
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            x_req = 1'b0; x_burst = 1'b0; p_req = 1'b0; p_we = 1'b0;
            atNeg();
            tick();
        end
    endtask

    initial begin
        int k;
        bit expG;
        nCompared = 0; nMismatched = 0;
        rst = 1'b0;
        p_req = 1'b1; p_we = 1'b1; p_addr = 32'h30; p_wdata = 32'h1;
        x_req = 1'b1; x_we = 1'b1; x_burst = 1'b0; x_addr = 32'h10; x_wdata = 32'h2;

        // Reset state with both requesters asserting writes
        atNeg();
        checkEq("rst_x_gnt", 32'(x_gnt), 32'd0);
        checkEq("rst_mem_we", 32'(mem_we), 32'd0);
        checkEq("rst_p_stall", 32'(p_stall), 32'd0);
        checkEq("rst_x_rvalid", 32'(x_rvalid), 32'd0);
        checkEq("rst_x_rdata", x_rdata, 32'd0);
        tick();
        rst = 1'b1;
        idle(1);

        // Idle slot: X write then X read of 0x10
        p_req = 1'b0; x_req = 1'b1; x_we = 1'b1; x_addr = 32'h10; x_wdata = 32'hDEADBEEF;
        atNeg();
        checkEq("idle_wr_gnt", 32'(x_gnt), 32'd1);
        checkEq("idle_wr_mem_we", 32'(mem_we), 32'd1);
        tick();
        x_we = 1'b0;
        atNeg();
        checkEq("idle_rd_gnt", 32'(x_gnt), 32'd1);
        checkEq("idle_rd_p_stall", 32'(p_stall), 32'd0);
        expQ.push_back(32'hDEADBEEF);
        tick();
        x_req = 1'b0;
        atNeg();
        checkEq("idle_rvalid", 32'(x_rvalid), 32'd1);
        checkEq("idle_rdata", x_rdata, 32'hDEADBEEF);
        checkEq("idle_p_stall", 32'(p_stall), 32'd0);
        tick();
        atNeg();
        checkEq("idle_rvalid_drop", 32'(x_rvalid), 32'd0);
        tick();

        // Starvation: P loads every cycle, X forced in cycle 4 only
        for (int c = 0; c < 6; c++) begin
            p_req = 1'b1; p_we = 1'b0; p_addr = 32'h30;
            x_req = (c < 5); x_we = 1'b0; x_burst = 1'b0; x_addr = 32'h10;
            atNeg();
            checkEq($sformatf("starve_gnt_c%0d", c), 32'(x_gnt), 32'(c == 4));
            checkEq($sformatf("starve_stall_c%0d", c), 32'(p_stall), 32'(c == 4));
            checkEq($sformatf("starve_addr_c%0d", c), mem_addr, (c == 4) ? 32'h10 : 32'h30);
            if (c == 4) expQ.push_back(32'hDEADBEEF);
            tick();
        end
        idle(1);

        // Burst cap: forced entry at cycle 4, 8 grants, then P gets a slot
        k = 0;
        for (int c = 0; c < 13; c++) begin
            p_req = 1'b1; p_we = 1'b0; p_addr = 32'h30;
            x_req = 1'b1; x_burst = 1'b1; x_we = 1'b1;
            x_addr = 32'h100 + 32'(4 * k); x_wdata = 32'hB000_0000 + 32'(k);
            expG = (c >= 4 && c <= 11);
            atNeg();
            checkEq($sformatf("burst_gnt_c%0d", c), 32'(x_gnt), 32'(expG));
            checkEq($sformatf("burst_stall_c%0d", c), 32'(p_stall), 32'(expG));
            checkEq($sformatf("burst_we_c%0d", c), 32'(mem_we), 32'(expG));
            tick();
            if (expG) k++;
        end
        idle(1);
        for (int i = 0; i < 8; i++)
            checkEq($sformatf("burst_mem_%0d", i), mem[8'h40 + 8'(i)], 32'hB000_0000 + 32'(i));

        // Early exit: x_burst dropped on the third grant
        k = 0;
        for (int c = 0; c < 9; c++) begin
            p_req = 1'b1; p_we = 1'b0; p_addr = 32'h30;
            x_req = (c <= 7); x_burst = (c <= 5); x_we = 1'b0;
            x_addr = 32'h100 + 32'(4 * k);
            expG = (c >= 4 && c <= 6);
            atNeg();
            checkEq($sformatf("early_gnt_c%0d", c), 32'(x_gnt), 32'(expG));
            checkEq($sformatf("early_stall_c%0d", c), 32'(p_stall), 32'(expG));
            if (expG) begin
                expQ.push_back(32'hB000_0000 + 32'(k));
                k++;
            end
            tick();
        end
        idle(1);

        // Conflicting stores: P first, X in the following idle slot
        p_req = 1'b1; p_we = 1'b1; p_addr = 32'h20; p_wdata = 32'h55;
        x_req = 1'b1; x_we = 1'b1; x_burst = 1'b0; x_addr = 32'h24; x_wdata = 32'hAA;
        atNeg();
        checkEq("conf_c0_gnt", 32'(x_gnt), 32'd0);
        checkEq("conf_c0_stall", 32'(p_stall), 32'd0);
        checkEq("conf_c0_we", 32'(mem_we), 32'd1);
        checkEq("conf_c0_addr", mem_addr, 32'h20);
        checkEq("conf_c0_wdata", mem_wdata, 32'h55);
        tick();
        p_req = 1'b0; p_we = 1'b0;
        atNeg();
        checkEq("conf_c1_gnt", 32'(x_gnt), 32'd1);
        checkEq("conf_c1_addr", mem_addr, 32'h24);
        checkEq("conf_c1_wdata", mem_wdata, 32'hAA);
        tick();
        x_req = 1'b0;
        atNeg();
        checkEq("conf_mem_20", mem[8'h08], 32'h55);
        checkEq("conf_mem_24", mem[8'h09], 32'hAA);
        tick();

        // Reset during the third burst grant with a read in flight
        k = 0;
        for (int c = 0; c < 6; c++) begin
            p_req = 1'b1; p_we = 1'b0; p_addr = 32'h30;
            x_req = 1'b1; x_burst = 1'b1; x_we = 1'b0;
            x_addr = 32'h100 + 32'(4 * k);
            expG = (c >= 4);
            atNeg();
            checkEq($sformatf("rstb_gnt_c%0d", c), 32'(x_gnt), 32'(expG));
            if (expG) begin
                expQ.push_back(32'hB000_0000 + 32'(k));
                k++;
            end
            tick();
        end
        rst = 1'b0;
        #1;
        checkEq("rstb_gnt_now", 32'(x_gnt), 32'd0);
        checkEq("rstb_we_now", 32'(mem_we), 32'd0);
        checkEq("rstb_rvalid_now", 32'(x_rvalid), 32'd0);
        checkEq("rstb_stall_now", 32'(p_stall), 32'd0);
        atNeg();
        checkEq("rstb_rdata", x_rdata, 32'd0);
        tick();
        atNeg();
        tick();
        rst = 1'b1;
        for (int c = 0; c < 6; c++) begin
            p_req = 1'b1; p_we = 1'b0; p_addr = 32'h30;
            x_req = (c <= 4); x_burst = 1'b1; x_we = 1'b0; x_addr = 32'h108;
            atNeg();
            checkEq($sformatf("post_rst_gnt_c%0d", c), 32'(x_gnt), 32'(c == 4));
            checkEq($sformatf("post_rst_stall_c%0d", c), 32'(p_stall), 32'(c == 4));
            if (c == 4) expQ.push_back(32'hB000_0002);
            tick();
        end
        idle(2);

        checkEq("sb_drained", 32'(expQ.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule
